// File: rtl/pc_unit.sv
// Program-counter stage: holds PC, forms sequential/branch/jump targets and the fetch request,
// and enters the exception vector on overflow. Define ALIGN_CHECK_EN to trap misaligned JR/ERET targets.
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        ovf,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        j_taken,
  input  logic [25:0] j_index,
  input  logic        jr_taken,
  input  logic [31:0] jr_addr,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        exc_active
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    EXC  = 2'd2
  } state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_OV   = 5'd12;

  state_t      state;
  logic        advance;
  logic        ovf_take;
  logic        align_err;
  logic        exc_take;
  logic [4:0]  exc_code;
  logic        reg_path;
  logic [31:0] reg_tgt;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] next_pc;

  // All address arithmetic is plain modulo-2^32; carry-out is deliberately dropped.
  assign npc      = pc + 32'd4;
  assign advance  = (state == RUN) && imem_ready && !stall;
  assign ovf_take = (state == RUN) && ovf && !exc_active;
  assign reg_path = eret || jr_taken;
  assign reg_tgt  = eret ? epc : jr_addr;
  assign br_tgt   = npc + (br_offset << 2);
  assign j_tgt    = {npc[31:28], j_index, 2'b00};

  // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
  always_comb begin
    next_pc = npc;
    if (reg_path) begin
      next_pc = reg_tgt & ~32'd3;
    end else if (j_taken) begin
      next_pc = j_tgt;
    end else if (br_taken) begin
      next_pc = br_tgt;
    end
  end

`ifdef ALIGN_CHECK_EN
  // A misaligned register target traps only outside exception level; inside it is truncated.
  assign align_err = advance && reg_path && (reg_tgt[1:0] != 2'b00) && !exc_active;
`else
  assign align_err = 1'b0;
`endif

  assign exc_take = ovf_take || align_err;
  assign exc_code = ovf_take ? EXC_OV : EXC_ADEL;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      epc        <= 32'd0;
      cause      <= EXC_NONE;
      exc_active <= 1'b0;
      imem_req   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          imem_req <= 1'b1;
        end
        RUN: begin
          if (exc_take) begin
            // Entry aborts the in-flight fetch regardless of imem_ready/stall.
            epc        <= pc;
            cause      <= exc_code;
            exc_active <= 1'b1;
            state      <= EXC;
            imem_req   <= 1'b0;
          end else if (advance) begin
            pc <= next_pc;
            if (eret) begin
              exc_active <= 1'b0;
              cause      <= EXC_NONE;
            end
          end
        end
        EXC: begin
          pc       <= EXC_VECTOR;
          state    <= RUN;
          imem_req <= 1'b1;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver feeds directed then random control inputs into a
// behavioural model and queues expected state; a monitor pops and compares after each edge.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_4180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        ovf = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        j_taken = 1'b0;
  logic [25:0] j_index = '0;
  logic        jr_taken = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        eret = 1'b0;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        imem_req;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        exc_active;

  pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_ready (imem_ready),
    .stall      (stall),
    .ovf        (ovf),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .j_taken    (j_taken),
    .j_index    (j_index),
    .jr_taken   (jr_taken),
    .jr_addr    (jr_addr),
    .eret       (eret),
    .pc         (pc),
    .npc        (npc),
    .imem_req   (imem_req),
    .epc        (epc),
    .cause      (cause),
    .exc_active (exc_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        exl;
    logic        req;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state, described in terms of architectural effects.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;
  logic        m_exl;
  logic        m_req;
  bit          m_booting;
  bit          m_vector_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epc = '0; m_cause = 5'd0; m_exl = 1'b0; m_req = 1'b0;
    m_booting = 1'b1; m_vector_next = 1'b0;
  endtask

  task automatic model_trap(input logic [4:0] code);
    m_epc = m_pc; m_cause = code; m_exl = 1'b1; m_req = 1'b0; m_vector_next = 1'b1;
  endtask

  task automatic model_edge();
    logic [31:0] seq;
    logic [31:0] tgt;
    bit          via_reg;
    bit          align_on;
`ifdef ALIGN_CHECK_EN
    align_on = 1'b1;
`else
    align_on = 1'b0;
`endif
    if (m_booting) begin
      m_booting = 1'b0; m_req = 1'b1;
    end else if (m_vector_next) begin
      m_vector_next = 1'b0; m_pc = EXC_VECTOR; m_req = 1'b1;
    end else if (ovf && !m_exl) begin
      model_trap(5'd12);
    end else if (imem_ready && !stall) begin
      seq = m_pc + 32'd4;
      via_reg = eret || jr_taken;
      if (eret)          tgt = m_epc;
      else if (jr_taken) tgt = jr_addr;
      else if (j_taken)  tgt = {seq[31:28], j_index, 2'b00};
      else if (br_taken) tgt = seq + br_offset * 4;
      else               tgt = seq;
      if (via_reg && align_on && (tgt % 4 != 0) && !m_exl) begin
        model_trap(5'd4);
      end else begin
        m_pc = via_reg ? (tgt - (tgt % 4)) : tgt;
        if (eret) begin
          m_exl = 1'b0; m_cause = 5'd0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state expected after the rise.
  task automatic step(input bit rdy, input bit stl, input bit o, input bit br, input logic [31:0] off,
                      input bit j, input logic [25:0] idx, input bit jr, input logic [31:0] ja,
                      input bit er);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    imem_ready = rdy; stall = stl; ovf = o; br_taken = br; br_offset = off;
    j_taken = j; j_index = idx; jr_taken = jr; jr_addr = ja; eret = er;
    model_edge();
    e.pc = m_pc; e.epc = m_epc; e.cause = m_cause; e.exl = m_exl; e.req = m_req;
    exp_q.push_back(e);
  endtask

  task automatic seq_step();
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc"},         pc,         RESET_PC);
    check({tag, ".npc"},        npc,        RESET_PC + 32'd4);
    check({tag, ".epc"},        epc,        32'd0);
    check({tag, ".cause"},      {27'd0, cause},      32'd0);
    check({tag, ".exc_active"}, {31'd0, exc_active}, 32'd0);
    check({tag, ".imem_req"},   {31'd0, imem_req},   32'd0);
  endtask

  // Monitor: compares DUT state against the oldest queued expectation after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",         pc,  e.pc);
        check("npc",        npc, e.pc + 32'd4);
        check("epc",        epc, e.epc);
        check("cause",      {27'd0, cause},      {27'd0, e.cause});
        check("exc_active", {31'd0, exc_active}, {31'd0, e.exl});
        check("imem_req",   {31'd0, imem_req},   {31'd0, e.req});
      end
    end
  end

  initial begin
    logic [31:0] off;
    model_reset();
    #7;
    check_reset_values("por");

    // Boot, then sequential fetch 0x00400000 -> 0x00400010.
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    repeat (4) seq_step();
    // Backward branch from 0x00400010 by -2 words, then a stalled cycle.
    step(1, 0, 0, 1, 32'hFFFF_FFFE, 0, '0, 0, '0, 0);
    step(1, 1, 0, 0, '0, 1, 26'h3FF_FFFF, 0, '0, 0);
    step(0, 0, 0, 1, 32'h10, 0, '0, 0, '0, 0);
    // Jump to 0x00400020, then overflow with the fetch not yet accepted.
    step(1, 0, 0, 0, '0, 0, '0, 1, 32'h0040_0020, 0);
    step(0, 0, 1, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 1, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 1);
    // Misaligned register jump; trap when the check is built in, truncate otherwise.
    step(1, 0, 0, 0, '0, 0, '0, 1, 32'h0040_0102, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 1);
    // Address wrap at the top of the space, and a jump keeping the region bits.
    step(1, 0, 0, 0, '0, 0, '0, 1, 32'hFFFF_FFFC, 0);
    seq_step();
    step(1, 0, 0, 0, '0, 1, 26'h123_4567, 0, '0, 0);
    step(1, 0, 1, 0, '0, 0, '0, 0, '0, 1);
    step(1, 0, 1, 0, '0, 0, '0, 0, '0, 1);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 1);

    // Randomized control traffic.
    for (int i = 0; i < 400; i++) begin
      off = 32'($urandom_range(0, 63)) - 32'd32;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0, off, $urandom_range(0, 9) == 0, 26'($urandom),
           $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 11) == 0);
    end

    // Leave exception level, trap, and hit reset asynchronously while in EXC.
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 1);
    step(1, 0, 1, 0, '0, 0, '0, 0, '0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    step(1, 0, 0, 0, '0, 0, '0, 0, '0, 0);
    repeat (3) seq_step();

    @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
